seg_scan: RTL and testbench
===========================

Name: seg_scan

Overview:
- Downstream consumer of the clock divider's slowclk output.
- Time-multiplexes a NUM_DIGITS-digit common-anode seven-segment display, advancing one digit per slowclk rising edge.
- Runs entirely on fastclk; slowclk is treated as an asynchronous level, synchronized and edge-detected, never used as a clock.
- Latches the display value once per frame so a digit never shows a torn value.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (2..8).
- IDX_W, 3: digit index width; must satisfy 2**IDX_W >= NUM_DIGITS.

Ports:
- fastclk  in  1  system clock, 50 MHz, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- slowclk  in  1  scan-rate square wave from the clock divider, asynchronous to this block.
- enable  in  1  1 = scan; 0 = display blanked.
- value  in  4*NUM_DIGITS  hex nibbles; value[3:0] = digit 0 (rightmost).
- an_n  out  NUM_DIGITS  active-low anode selects, one-hot-low when scanning.
- seg_n  out  7  active-low segments; bit0=a .. bit6=g.
- frame_done  out  1  one-cycle pulse when a new frame starts (value latched).

Behaviour:
- Reset is asynchronous, active-low, on rst_n (single clock fastclk). While asserted:
  - sync flops s1/s2/s3 = 0; idx = NUM_DIGITS-1; shadow = 0.
  - an_n = all 1s; seg_n = 7'h7F; frame_done = 0.
- Synchronizer: s1 <= slowclk; s2 <= s1; s3 <= s2; tick = s2 & ~s3. Falling edges are ignored.
- Latency: slowclk rise first sampled into s1 at edge N -> tick high during cycle after edge N+1 -> an_n/seg_n/idx/frame_done update at edge N+2.
- On tick with enable=1:
  - idx_next = (idx == NUM_DIGITS-1) ? 0 : idx+1.
  - an_n <= ~(1 << idx_next).
  - seg_n <= decode(nibble idx_next of the source data).
- Frame start: when idx_next == 0, shadow <= value and frame_done <= 1 for exactly one cycle. Digit 0 decodes from the new value in that same cycle (bypass); all other digits decode from shadow.
- No tick: all outputs hold; frame_done <= 0.
- enable=0, at next edge:
  - an_n = all 1s; seg_n = 7'h7F; idx = NUM_DIGITS-1; frame_done = 0.
  - Ticks are ignored.
- enable 0->1: the first subsequent tick selects digit 0 and starts a frame (latch + frame_done). Scanning never resumes mid-frame.
- Simultaneous tick and enable falling: enable wins; outputs blank, no frame_done.
- value changes mid-frame are invisible until the next frame start.
- Hex decode, active-low, gfedcba:
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
  - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E
- Reset asserted mid-scan blanks immediately (asynchronous). After release, the first tick starts a frame at digit 0.

Optional Feature:
- Macro: SEG_SCAN_ZERO_BLANK_EN.
- Defined: leading-zero suppression. A digit k > 0 is driven seg_n = 7'h7F (its anode still asserted) when its shadow nibble and all higher nibbles are 0. Digit 0 is never suppressed, so value 0 displays "0".
- Undefined: every digit is always decoded. Suppression logic is absent from the netlist.

Test Plan (NUM_DIGITS=4, slowclk period 20 fastclk cycles):
- Reset release, enable=1, value=16'h12AF, first slowclk rise at edge N -> at edge N+2: an_n=4'b1110, seg_n=7'h0E, frame_done=1 for one cycle.
- Continue 4 more rises -> an_n sequence 1101 (A=08), 1011 (2=24), 0111 (1=79), then 1110 with a second frame_done; no frame_done between.
- Change value to 16'h0000 while an_n=1101 -> digits 2 and 3 still show 2 and 1; new value appears from the next digit-0 frame.
- Deassert enable while an_n=1011 -> next edge an_n=4'b1111, seg_n=7'h7F. Reassert -> first tick gives an_n=1110 with frame_done.
- Glitch-free check: slowclk held high for 100 cycles -> exactly one digit advance; falling edge causes no change.
- With SEG_SCAN_ZERO_BLANK_EN defined, value=16'h0070 -> digit 3 and digit 2 seg_n=7F, digit 1 seg_n=78, digit 0 seg_n=40. Without the macro, digit 3 and digit 2 seg_n=40.

Source files
------------

// File: rtl/seg_scan.sv
// seg_scan: multiplexed common-anode 7-segment scanner, one digit per slowclk rise.
// Optional SEG_SCAN_ZERO_BLANK_EN: leading-zero suppression on digits above 0.
module seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = 3
) (
  input  logic                    fastclk,
  input  logic                    rst_n,
  input  logic                    slowclk,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n,
  output logic                    frame_done
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DIGITS - 1);

  logic                    s1, s2, s3;
  logic                    tick;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_next;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    frame_start;
  logic [3:0]              nib;
  logic                    blank_digit;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              seg_next;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // slowclk is an async level: 2-flop sync plus a third flop for rise detect
  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= slowclk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // next digit, its anode pattern and source nibble (digit 0 bypasses shadow)
  always_comb begin
    tick        = s2 & ~s3;
    idx_next    = (idx == LAST) ? '0 : idx + 1'b1;
    frame_start = (idx_next == '0);
    nib         = value[3:0];
    an_next     = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_next == IDX_W'(k)) begin
        an_next[k] = 1'b0;
        if (k != 0) nib = shadow[4*k +: 4];
      end
    end
  end

`ifdef SEG_SCAN_ZERO_BLANK_EN
  // blank digit k>0 when it and every higher shadow nibble are zero
  always_comb begin
    logic all_zero;
    all_zero    = 1'b1;
    blank_digit = 1'b0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      all_zero = all_zero & (shadow[4*k +: 4] == 4'h0);
      if (idx_next == IDX_W'(k)) blank_digit = all_zero;
    end
  end
`else
  assign blank_digit = 1'b0;
`endif

  // segment pattern for the digit about to be selected
  always_comb begin
    seg_next = blank_digit ? 7'h7F : hex7(nib);
  end

  // scan state: enable dominates, ticks advance, frame start latches value
  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= LAST;
      shadow     <= '0;
      an_n       <= '1;
      seg_n      <= 7'h7F;
      frame_done <= 1'b0;
    end else if (!enable) begin
      idx        <= LAST;
      an_n       <= '1;
      seg_n      <= 7'h7F;
      frame_done <= 1'b0;
    end else if (tick) begin
      idx        <= idx_next;
      an_n       <= an_next;
      seg_n      <= seg_next;
      frame_done <= frame_start;
      if (frame_start) shadow <= value;
    end else begin
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: table-driven scan vectors with a queued scoreboard
// plus hand sequences for enable, glitch, and reset corner cases.
module tb_seg_scan;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  typedef struct packed {
    logic [15:0] value;
    exp_t        e;
  } vec_t;

`ifdef SEG_SCAN_ZERO_BLANK_EN
  localparam logic [6:0] ZS = 7'h7F;
`else
  localparam logic [6:0] ZS = 7'h40;
`endif

  localparam exp_t BLANK = {4'hF, 7'h7F, 1'b0};

  logic        fastclk = 1'b0;
  logic        rst_n;
  logic        slowclk;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        frame_done;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t cur;
  exp_t exp_q[$];
  vec_t tbl[28];

  seg_scan #(.NUM_DIGITS(4), .IDX_W(3)) dut (
    .fastclk    (fastclk),
    .rst_n      (rst_n),
    .slowclk    (slowclk),
    .enable     (enable),
    .value      (value),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .frame_done (frame_done)
  );

  always #5 fastclk = ~fastclk;

  function automatic vec_t mk(logic [15:0] v, logic [3:0] an,
                              logic [6:0] seg, logic fd);
    return {v, an, seg, fd};
  endfunction

  task automatic check(input string name, input exp_t e);
    n_checks++;
    if (an_n !== e.an || seg_n !== e.seg || frame_done !== e.fd) begin
      n_fail++;
      $display("FAIL %s: got an_n=%b seg_n=%h fd=%b want an_n=%b seg_n=%h fd=%b",
               name, an_n, seg_n, frame_done, e.an, e.seg, e.fd);
    end
  endtask

  // one slowclk pulse; outputs must move exactly at edge N+2
  task automatic rise(input string name, input exp_t e, input int hi);
    exp_t got;
    exp_t hold;
    exp_q.push_back(e);
    @(negedge fastclk) slowclk = 1'b1;
    @(posedge fastclk);
    @(posedge fastclk);
    #1 check({name, "_lat"}, {cur.an, cur.seg, 1'b0});
    @(posedge fastclk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      got = exp_q.pop_front();
      check(name, got);
      cur = got;
    end
    hold = {cur.an, cur.seg, 1'b0};
    @(posedge fastclk);
    #1 check({name, "_fd1"}, hold);
    repeat (hi - 4) @(posedge fastclk);
    #1 check({name, "_hi"}, hold);
    @(negedge fastclk) slowclk = 1'b0;
    repeat (10) @(posedge fastclk);
    #1 check({name, "_lo"}, hold);
  endtask

  initial begin
    tbl[0]  = mk(16'h12AF, 4'b1110, 7'h0E, 1'b1);
    tbl[1]  = mk(16'h12AF, 4'b1101, 7'h08, 1'b0);
    tbl[2]  = mk(16'h12AF, 4'b1011, 7'h24, 1'b0);
    tbl[3]  = mk(16'h12AF, 4'b0111, 7'h79, 1'b0);
    tbl[4]  = mk(16'h12AF, 4'b1110, 7'h0E, 1'b1);
    tbl[5]  = mk(16'h12AF, 4'b1101, 7'h08, 1'b0);
    tbl[6]  = mk(16'h0000, 4'b1011, 7'h24, 1'b0);
    tbl[7]  = mk(16'h0000, 4'b0111, 7'h79, 1'b0);
    tbl[8]  = mk(16'h0000, 4'b1110, 7'h40, 1'b1);
    tbl[9]  = mk(16'h0000, 4'b1101, ZS,    1'b0);
    tbl[10] = mk(16'h0070, 4'b1011, ZS,    1'b0);
    tbl[11] = mk(16'h0070, 4'b0111, ZS,    1'b0);
    tbl[12] = mk(16'h0070, 4'b1110, 7'h40, 1'b1);
    tbl[13] = mk(16'h0070, 4'b1101, 7'h78, 1'b0);
    tbl[14] = mk(16'h0070, 4'b1011, ZS,    1'b0);
    tbl[15] = mk(16'h0070, 4'b0111, ZS,    1'b0);
    tbl[16] = mk(16'h9E6B, 4'b1110, 7'h03, 1'b1);
    tbl[17] = mk(16'h9E6B, 4'b1101, 7'h02, 1'b0);
    tbl[18] = mk(16'h9E6B, 4'b1011, 7'h06, 1'b0);
    tbl[19] = mk(16'h9E6B, 4'b0111, 7'h10, 1'b0);
    tbl[20] = mk(16'h4D78, 4'b1110, 7'h00, 1'b1);
    tbl[21] = mk(16'h4D78, 4'b1101, 7'h78, 1'b0);
    tbl[22] = mk(16'h4D78, 4'b1011, 7'h21, 1'b0);
    tbl[23] = mk(16'h4D78, 4'b0111, 7'h19, 1'b0);
    tbl[24] = mk(16'h5C30, 4'b1110, 7'h40, 1'b1);
    tbl[25] = mk(16'h5C30, 4'b1101, 7'h30, 1'b0);
    tbl[26] = mk(16'h5C30, 4'b1011, 7'h46, 1'b0);
    tbl[27] = mk(16'h5C30, 4'b0111, 7'h12, 1'b0);

    rst_n   = 1'b0;
    slowclk = 1'b0;
    enable  = 1'b1;
    value   = 16'h12AF;
    cur     = BLANK;
    repeat (3) @(posedge fastclk);
    #1 check("reset", BLANK);
    @(negedge fastclk) rst_n = 1'b1;
    repeat (3) @(posedge fastclk);
    #1 check("post_reset", BLANK);

    for (int i = 0; i < 28; i++) begin
      @(negedge fastclk) value = tbl[i].value;
      rise($sformatf("vec%0d", i), tbl[i].e, 10);
    end

    rise("glitch", {4'b1110, 7'h40, 1'b1}, 100);
    rise("g2", {4'b1101, 7'h30, 1'b0}, 10);
    rise("g3", {4'b1011, 7'h46, 1'b0}, 10);

    @(negedge fastclk) enable = 1'b0;
    @(posedge fastclk);
    #1 check("en_off", BLANK);
    cur = BLANK;
    rise("en_off_tick", BLANK, 10);

    @(negedge fastclk) begin
      enable = 1'b1;
      value  = 16'h12AF;
    end
    rise("en_on", {4'b1110, 7'h0E, 1'b1}, 10);
    rise("en_on2", {4'b1101, 7'h08, 1'b0}, 10);

    @(negedge fastclk) slowclk = 1'b1;
    @(posedge fastclk);
    @(posedge fastclk);
    @(negedge fastclk) enable = 1'b0;
    @(posedge fastclk);
    #1 check("tick_vs_en", BLANK);
    cur = BLANK;
    @(negedge fastclk) slowclk = 1'b0;
    repeat (10) @(posedge fastclk);
    @(negedge fastclk) enable = 1'b1;
    rise("resume", {4'b1110, 7'h0E, 1'b1}, 10);
    rise("resume2", {4'b1101, 7'h08, 1'b0}, 10);

    @(negedge fastclk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", BLANK);
    cur = BLANK;
    @(negedge fastclk) rst_n = 1'b1;
    repeat (3) @(posedge fastclk);
    rise("rst_frame", {4'b1110, 7'h0E, 1'b1}, 10);
    rise("rst_d1", {4'b1101, 7'h08, 1'b0}, 10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
